xadc_drp_scheduler: RTL and testbench
=====================================

// Module: xadc_drp_scheduler
// PURPOSE
//  Sequencer and arbiter for the 7-series XADC DRP port. Scans enabled status channels
//  (DRP addr = channel index) on a fixed period and latches 12-bit results.
//  A host (CPU register path) shares the same DRP. Host access has priority at
//  transaction boundaries. Sits between the xadc_7000 register block and the XADC primitive.
// PARAMETERS
//  NCH      8     number of scanned channels, DRP addresses 0..NCH-1 (1..32)
//  PERIOD   1000  aclk cycles between scan starts (>= 16)
//  TIMEOUT  255   max aclk cycles waiting drp_drdy before abort (>= 2)
// PORTS
//  aclk         in   1        clock
//  aresetn      in   1        asynchronous active-low reset
//  scan_en      in   1        1 = periodic scanning enabled
//  ch_mask      in   NCH      channel i scanned when ch_mask[i]=1
//  host_req     in   1        host DRP request, held until host_ack
//  host_we      in   1        1 = write, 0 = read (sampled with host_req)
//  host_addr    in   7        host DRP address
//  host_di      in   16       host write data
//  host_ack     out  1        1-cycle pulse: host transaction complete
//  host_do      out  16       host read data, valid with host_ack, held after
//  host_err     out  1        valid with host_ack: 1 = timed out
//  drp_den      out  1        DRP enable, 1-cycle pulse per transaction
//  drp_dwe      out  1        DRP write enable, valid with drp_den only
//  drp_daddr    out  7        DRP address, held from den until drdy/abort
//  drp_di       out  16       DRP write data
//  drp_do       in   16       DRP read data, valid with drp_drdy
//  drp_drdy     in   1        DRP transaction done
//  res_data     out  NCH*12   latest result of ch i at [12i+11:12i] = drp_do[15:4]
//  res_valid    out  1        1-cycle pulse when any res_data slot updates
//  res_ch       out  5        channel index of that update
//  scan_done    out  1        1-cycle pulse after last enabled channel of a scan
//  overrun      out  1        sticky: period tick arrived while scan still active
//  timeout_cnt  out  8        count of aborted DRP transactions, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE. Period counter=0. scan_pend=0.
//  Period counter: counts 0..PERIOD-1 while scan_en=1, else held at 0.
//   Wrap sets scan_pend. If a scan is active or scan_pend is already 1, set overrun
//   instead. No second scan is queued.
//  Scan start: scan_pend and FSM idle. ch_ptr <= lowest set bit of ch_mask, scan_pend <= 0.
//   ch_mask = 0: scan_done pulses the next cycle, no DRP traffic.
//  FSM IDLE: host_req -> ISSUE(host). Else scan active -> ISSUE(scan, ch_ptr). Else stay.
//  ISSUE (1 cycle): drp_den=1, drp_dwe=host_we for host and 0 for scan, address/data driven.
//   Then WAIT with timer=0.
//  WAIT: on drp_drdy -> DONE and capture drp_do.
//   On timer==TIMEOUT-1 without drdy -> DONE with err=1; timeout_cnt++ (saturating).
//   drdy in the same cycle as timeout takes priority (not an error).
//  DONE (1 cycle):
//   host: host_ack=1, host_do=capture (unchanged on write or err), host_err=err.
//   scan: if !err, update res slot ch_ptr, res_valid=1, res_ch=ch_ptr. On err, slot unchanged.
//   Scan advance: ch_ptr <= next set bit above ch_ptr in ch_mask, sampled now.
//   None left: scan_done=1 in this cycle, scan ends.
//  DONE -> IDLE, so host and scan alternate when both pend. Worst host wait: one scan txn.
//  Minimum txn: den, drdy next cycle gives 4 cycles den-to-den.
//  drp_drdy outside WAIT is ignored.
//  scan_en falling mid-scan: the current scan completes. The counter resets.
//  ch_mask change mid-scan: takes effect at the next advance.
//  host_req deasserted before ack is a protocol violation (undefined).
//  aresetn low mid-transaction: immediate return to reset state.
//   The DRP may still return drdy, which is ignored.
// TESTING
//  T1 NCH=8, mask=8'h05, PERIOD=64, drdy 3 cycles after den, do=16'hABC0
//     -> den at addr 0 then 2; res slots 0,2 = 12'hABC; res_ch 0,2; one scan_done per 64 cycles.
//  T2 host read addr 7'h40 during scan -> served after current scan txn.
//     host_do=model value, host_ack 1 cycle, scan resumes at next channel.
//  T3 host write 7'h41 data 16'h2000 -> drp_dwe=1 with den, drp_di=16'h2000, host_err=0.
//  T4 no drdy, TIMEOUT=8 -> abort 8 cycles after den.
//     timeout_cnt=1, slot unchanged, scan continues; host case gives host_err=1.
//  T5 drdy delay 200, PERIOD=64, mask=8'hFF -> overrun=1 stays set.
//     Scans complete back-to-back without loss of order.
//  T6 aresetn low 2 cycles in WAIT, then a late drdy -> all outputs 0, late drdy ignored.
//     First den follows PERIOD cycles after release.

Source files
------------

// File: rtl/xadc_drp_scheduler.sv
// xadc_drp_scheduler: periodic XADC status-channel scanner sharing the DRP port with a host.
// Host wins at transaction boundaries; every transaction returns through IDLE so both alternate.
module xadc_drp_scheduler #(
    parameter int NCH     = 8,
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 255
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              scan_en,
    input  logic [NCH-1:0]    ch_mask,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [6:0]        host_addr,
    input  logic [15:0]       host_di,
    output logic              host_ack,
    output logic [15:0]       host_do,
    output logic              host_err,
    output logic              drp_den,
    output logic              drp_dwe,
    output logic [6:0]        drp_daddr,
    output logic [15:0]       drp_di,
    input  logic [15:0]       drp_do,
    input  logic              drp_drdy,
    output logic [NCH*12-1:0] res_data,
    output logic              res_valid,
    output logic [4:0]        res_ch,
    output logic              scan_done,
    output logic              overrun,
    output logic [7:0]        timeout_cnt
);
    localparam int CW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [4:0]        ptr_q, ptr_d, rch_q, rch_d, lo, nx;
    logic [6:0]        addr_q, addr_d;
    logic [15:0]       di_q, di_d, hdo_q, hdo_d;
    logic [NCH*12-1:0] res_q, res_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic              pend_q, pend_d, active_q, active_d, host_q, host_d, we_q, we_d;
    logic              err_q, err_d, ovr_q, ovr_d, zdone_q, zdone_d;
    logic              lo_ok, nx_ok, tick;

    // Descending scan so the lowest qualifying bit is the one left standing.
    always_comb begin
        lo = '0;
        lo_ok = 1'b0;
        nx = '0;
        nx_ok = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                lo = 5'(i);
                lo_ok = 1'b1;
            end
            if (ch_mask[i] && 5'(i) > ptr_q) begin
                nx = 5'(i);
                nx_ok = 1'b1;
            end
        end
    end

    assign tick = scan_en && cnt_q == CW'(PERIOD - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = scan_en ? (tick ? '0 : cnt_q + 1'b1) : '0;
        timer_d  = timer_q;
        ptr_d    = ptr_q;
        rch_d    = rch_q;
        addr_d   = addr_q;
        di_d     = di_q;
        hdo_d    = hdo_q;
        res_d    = res_q;
        tcnt_d   = tcnt_q;
        pend_d   = pend_q;
        active_d = active_q;
        host_d   = host_q;
        we_d     = we_q;
        err_d    = err_q;
        ovr_d    = ovr_q;
        zdone_d  = 1'b0;
        if (pend_q && state_q == IDLE) begin
            pend_d   = 1'b0;
            ptr_d    = lo;
            active_d = lo_ok;
            zdone_d  = !lo_ok;
        end
        if (tick) begin
            if (active_q || pend_q) ovr_d = 1'b1;
            else pend_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (host_req) begin
                    state_d = ISSUE;
                    host_d  = 1'b1;
                    we_d    = host_we;
                    addr_d  = host_addr;
                    di_d    = host_di;
                end else if (active_q) begin
                    state_d = ISSUE;
                    host_d  = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = {2'b00, ptr_q};
                    di_d    = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (drp_drdy) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    if (host_q && !we_q) hdo_d = drp_do;
                    if (!host_q) rch_d = ptr_q;
                    for (int i = 0; i < NCH; i++)
                        if (!host_q && 5'(i) == ptr_q) res_d[12*i+:12] = drp_do[15:4];
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    tcnt_d  = tcnt_q == 8'hFF ? tcnt_q : tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                if (!host_q) begin
                    ptr_d    = nx_ok ? nx : ptr_q;
                    active_d = nx_ok;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            timer_q  <= '0;
            ptr_q    <= '0;
            rch_q    <= '0;
            addr_q   <= '0;
            di_q     <= '0;
            hdo_q    <= '0;
            res_q    <= '0;
            tcnt_q   <= '0;
            pend_q   <= 1'b0;
            active_q <= 1'b0;
            host_q   <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
            zdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            ptr_q    <= ptr_d;
            rch_q    <= rch_d;
            addr_q   <= addr_d;
            di_q     <= di_d;
            hdo_q    <= hdo_d;
            res_q    <= res_d;
            tcnt_q   <= tcnt_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            host_q   <= host_d;
            we_q     <= we_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
            zdone_q  <= zdone_d;
        end
    end

    assign drp_den     = state_q == ISSUE;
    assign drp_dwe     = drp_den && host_q && we_q;
    assign drp_daddr   = addr_q;
    assign drp_di      = di_q;
    assign host_ack    = state_q == DONE && host_q;
    assign host_err    = host_ack && err_q;
    assign host_do     = hdo_q;
    assign res_valid   = state_q == DONE && !host_q && !err_q;
    assign res_ch      = rch_q;
    assign res_data    = res_q;
    assign scan_done   = zdone_q || (state_q == DONE && !host_q && !nx_ok);
    assign overrun     = ovr_q;
    assign timeout_cnt = tcnt_q;
endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// tb_xadc_drp_scheduler: DRP responder model plus scoreboard of expected host/scan results.
module tb_xadc_drp_scheduler;
    localparam int NCH = 8, PERIOD = 64, TIMEOUT = 8;

    logic aclk = 1'b0, aresetn = 1'b0, scan_en = 1'b0, host_req = 1'b0, host_we = 1'b0;
    logic [NCH-1:0] ch_mask = '0;
    logic [6:0] host_addr = '0;
    logic [15:0] host_di = '0, drp_do = '0;
    logic drp_drdy = 1'b0;
    logic host_ack, host_err, drp_den, drp_dwe, res_valid, scan_done, overrun;
    logic [15:0] host_do, drp_di;
    logic [6:0] drp_daddr;
    logic [NCH*12-1:0] res_data;
    logic [4:0] res_ch;
    logic [7:0] timeout_cnt;

    xadc_drp_scheduler #(.NCH(NCH), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .aclk(aclk), .aresetn(aresetn), .scan_en(scan_en), .ch_mask(ch_mask),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_di(host_di),
        .host_ack(host_ack), .host_do(host_do), .host_err(host_err),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy), .res_data(res_data), .res_valid(res_valid),
        .res_ch(res_ch), .scan_done(scan_done), .overrun(overrun), .timeout_cnt(timeout_cnt));

    always #5 aclk = ~aclk;

    typedef struct {logic host; logic we; logic [6:0] addr; logic err; logic [15:0] data;} sb_t;
    typedef struct {logic we; logic [6:0] addr; logic [15:0] di; int lat; logic [15:0] exp_do; logic exp_err;} vec_t;

    int total = 0, bad = 0, cyc = 0, hlat = 3;
    logic [15:0] mem [128];
    int lat_of [128];
    sb_t sbq [$];
    logic [6:0] den_log [$];
    int den_t [$], done_t [$];
    logic [11:0] exp_res [NCH];
    logic [7:0] exp_tcnt = '0;
    logic [15:0] exp_hdo = '0;
    vec_t vecs [6];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NCH*12-1:0] res_model();
        logic [NCH*12-1:0] r;
        for (int i = 0; i < NCH; i++) r[12*i+:12] = exp_res[i];
        return r;
    endfunction

    // Responder and scoreboard: drdy driven lat cycles after den; lat 0 never answers.
    initial begin
        sb_t e;
        int cnt, l;
        logic armed;
        logic [6:0] ra;
        logic rwe;
        logic [15:0] rdi;
        armed = 1'b0;
        cnt = 0;
        forever begin
            @(negedge aclk);
            if (host_ack) begin
                if (sbq.size() == 0 || !sbq[0].host) begin
                    total++; bad++;
                    $display("FAIL host_ack_unexpected: got ack want none");
                    if (sbq.size() != 0) void'(sbq.pop_front());
                end else begin
                    e = sbq.pop_front();
                    if (!e.err && !e.we) exp_hdo = e.data;
                    chk("sb_host_err", 128'(host_err), 128'(e.err));
                    chk("sb_host_do", 128'(host_do), 128'(exp_hdo));
                end
            end
            if (res_valid) begin
                if (sbq.size() == 0 || sbq[0].host) begin
                    total++; bad++;
                    $display("FAIL res_valid_unexpected: got ch %0d want none", res_ch);
                    if (sbq.size() != 0) void'(sbq.pop_front());
                end else begin
                    e = sbq.pop_front();
                    exp_res[e.addr[2:0]] = e.data[15:4];
                    chk("sb_res_ch", 128'(res_ch), 128'(e.addr));
                    chk("sb_res_data", 128'(res_data), 128'(res_model()));
                end
            end
            if (scan_done) done_t.push_back(cyc);
            if (drp_den) begin
                den_log.push_back(drp_daddr);
                den_t.push_back(cyc);
                e.host = drp_daddr >= 7'(NCH);
                e.we = e.host && host_we;
                e.addr = drp_daddr;
                e.data = mem[drp_daddr];
                l = e.host ? hlat : lat_of[drp_daddr];
                e.err = (l == 0 || l > TIMEOUT);
                chk("den_dwe", 128'(drp_dwe), 128'(e.we));
                if (e.host) chk("den_host_addr", 128'(drp_daddr), 128'(host_addr));
                if (e.we) chk("den_di", 128'(drp_di), 128'(host_di));
                if (e.host || !e.err) sbq.push_back(e);
                if (e.err && exp_tcnt != 8'hFF) exp_tcnt++;
                armed = (l != 0);
                cnt = l;
                ra = drp_daddr;
                rwe = e.we;
                rdi = drp_di;
                drp_drdy = 1'b0;
            end else if (armed) begin
                cnt--;
                if (cnt == 0) begin
                    drp_drdy = 1'b1;
                    if (rwe) begin
                        mem[ra] = rdi;
                        drp_do = '0;
                    end else drp_do = mem[ra];
                    armed = 1'b0;
                end else drp_drdy = 1'b0;
            end else drp_drdy = 1'b0;
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, 128'({host_ack, host_do, host_err, drp_den, drp_dwe, drp_daddr, drp_di,
                               res_valid, res_ch, scan_done, overrun, timeout_cnt}), '0);
        chk({nm, "_res"}, 128'(res_data), '0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) exp_res[i] = '0;
        exp_tcnt = '0;
        exp_hdo = '0;
        sbq.delete();
        den_log.delete();
        den_t.delete();
        done_t.delete();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        scan_en = 1'b0;
        host_req = 1'b0;
        repeat (2) @(negedge aclk);
        chk_zero("reset");
        clear_model();
        aresetn = 1'b1;
    endtask

    task automatic host_op(input logic we, input logic [6:0] a, input logic [15:0] d, input int l,
                           output logic [15:0] rdo, output logic rerr, output logic ok);
        hlat = l;
        host_we = we;
        host_addr = a;
        host_di = d;
        host_req = 1'b1;
        ok = 1'b0;
        rdo = '0;
        rerr = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge aclk);
            if (host_ack) begin
                ok = 1'b1;
                rdo = host_do;
                rerr = host_err;
            end
        end
        host_req = 1'b0;
        @(negedge aclk);
        chk("host_ack_pulse", 128'(host_ack), '0);
    endtask

    task automatic wait_dens(input int n, input string nm);
        int k;
        k = 0;
        while (den_log.size() < n && k < 600) begin
            @(negedge aclk);
            k++;
        end
        chk({nm, "_den_seen"}, 128'(den_log.size() >= n), 128'(1));
    endtask

    task automatic wait_dones(input int n, input string nm);
        int k;
        k = 0;
        while (done_t.size() < n && k < 600) begin
            @(negedge aclk);
            k++;
        end
        chk({nm, "_done_seen"}, 128'(done_t.size() >= n), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $finish;
    end

    initial begin
        logic [15:0] rdo;
        logic rerr, ok;
        logic [NCH*12-1:0] t1exp;
        int r;
        vecs[0] = '{1'b0, 7'h40, 16'h0000, 3, 16'h1234, 1'b0};
        vecs[1] = '{1'b1, 7'h41, 16'h2000, 1, 16'h1234, 1'b0};
        vecs[2] = '{1'b0, 7'h41, 16'h0000, 2, 16'h2000, 1'b0};
        vecs[3] = '{1'b0, 7'h42, 16'h0000, 0, 16'h2000, 1'b1};
        vecs[4] = '{1'b0, 7'h42, 16'h0000, TIMEOUT, 16'h5A5A, 1'b0};
        vecs[5] = '{1'b0, 7'h40, 16'h0000, TIMEOUT + 1, 16'h5A5A, 1'b1};
        for (int i = 0; i < 128; i++) begin
            mem[i] = i < NCH ? 16'hABC0 : 16'h0000;
            lat_of[i] = 3;
        end
        mem[7'h40] = 16'h1234;
        mem[7'h42] = 16'h5A5A;
        @(negedge aclk);
        do_reset();

        // Host-only vectors (scan disabled)
        for (int i = 0; i < 6; i++) begin
            host_op(vecs[i].we, vecs[i].addr, vecs[i].di, vecs[i].lat, rdo, rerr, ok);
            chk($sformatf("vec%0d_ack", i), 128'(ok), 128'(1));
            chk($sformatf("vec%0d_do", i), 128'(rdo), 128'(vecs[i].exp_do));
            chk($sformatf("vec%0d_err", i), 128'(rerr), 128'(vecs[i].exp_err));
        end
        chk("vec_tcnt", 128'(timeout_cnt), 128'(8'd2));

        // T1: mask 05, three periods
        do_reset();
        ch_mask = 8'h05;
        scan_en = 1'b1;
        repeat (3 * PERIOD + 32) @(negedge aclk);
        scan_en = 1'b0;
        repeat (20) @(negedge aclk);
        chk("t1_den_count", 128'(den_log.size()), 128'(6));
        for (int i = 0; i < den_log.size() && i < 6; i++)
            chk($sformatf("t1_den%0d", i), 128'(den_log[i]), 128'(i % 2 ? 2 : 0));
        chk("t1_done_count", 128'(done_t.size()), 128'(3));
        if (done_t.size() >= 2) chk("t1_period", 128'(done_t[1] - done_t[0]), 128'(PERIOD));
        t1exp = '0;
        t1exp[11:0] = 12'hABC;
        t1exp[35:24] = 12'hABC;
        chk("t1_res", 128'(res_data), 128'(t1exp));
        chk("t1_overrun", 128'(overrun), '0);

        // T2: host read lands between scan transactions
        do_reset();
        for (int i = 0; i < NCH; i++) mem[i] = 16'((i + 1) * 4096 + i * 16);
        ch_mask = 8'hFF;
        scan_en = 1'b1;
        wait_dens(1, "t2");
        host_op(1'b0, 7'h40, 16'h0000, 3, rdo, rerr, ok);
        chk("t2_host_do", 128'(rdo), 128'(16'h1234));
        wait_dones(1, "t2");
        scan_en = 1'b0;
        repeat (4) @(negedge aclk);
        chk("t2_den_count", 128'(den_log.size()), 128'(9));
        for (int i = 0; i < den_log.size() && i < 9; i++)
            chk($sformatf("t2_den%0d", i), 128'(den_log[i]), 128'(i == 0 ? 0 : i == 1 ? 7'h40 : i - 1));
        chk("t2_res", 128'(res_data), 128'(res_model()));

        // T4: channel 1 never answers; scan continues to channel 2
        do_reset();
        lat_of[1] = 0;
        ch_mask = 8'h07;
        scan_en = 1'b1;
        wait_dones(1, "t4");
        scan_en = 1'b0;
        repeat (4) @(negedge aclk);
        lat_of[1] = 3;
        chk("t4_den_count", 128'(den_log.size()), 128'(3));
        if (den_log.size() >= 3) chk("t4_den2", 128'(den_log[2]), 128'(2));
        chk("t4_tcnt", 128'(timeout_cnt), 128'(8'd1));
        chk("t4_tcnt_model", 128'(timeout_cnt), 128'(exp_tcnt));
        chk("t4_slot1", 128'(res_data[23:12]), '0);
        chk("t4_res", 128'(res_data), 128'(res_model()));

        // T5: scans longer than the period
        do_reset();
        for (int i = 0; i < NCH; i++) lat_of[i] = 6;
        ch_mask = 8'hFF;
        scan_en = 1'b1;
        wait_dones(2, "t5");
        scan_en = 1'b0;
        chk("t5_overrun", 128'(overrun), 128'(1));
        if (done_t.size() >= 2) chk("t5_spacing", 128'(done_t[1] - done_t[0]), 128'(2 * PERIOD));
        chk("t5_den_count", 128'(den_log.size() >= 16), 128'(1));
        for (int i = 0; i < den_log.size() && i < 16; i++)
            chk($sformatf("t5_den%0d", i), 128'(den_log[i]), 128'(i % NCH));
        repeat (100) @(negedge aclk);
        chk("t5_overrun_sticky", 128'(overrun), 128'(1));
        chk("t5_tcnt", 128'(timeout_cnt), '0);
        for (int i = 0; i < NCH; i++) lat_of[i] = 3;

        // Empty mask: scan_done without DRP traffic
        do_reset();
        ch_mask = '0;
        scan_en = 1'b1;
        repeat (PERIOD + 6) @(negedge aclk);
        scan_en = 1'b0;
        chk("zm_done", 128'(done_t.size()), 128'(1));
        chk("zm_no_den", 128'(den_log.size()), '0);

        // T6: reset in WAIT, late drdy ignored
        do_reset();
        lat_of[0] = 5;
        ch_mask = 8'h01;
        scan_en = 1'b1;
        wait_dens(1, "t6");
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        chk_zero("t6_mid");
        clear_model();
        r = cyc;
        aresetn = 1'b1;
        repeat (10) @(negedge aclk);
        chk("t6_late_res", 128'(res_data), '0);
        chk("t6_late_tcnt", 128'(timeout_cnt), '0);
        wait_dens(1, "t6_after");
        if (den_t.size() >= 1) begin
            chk("t6_first_den_min", 128'(den_t[0] - r >= PERIOD), 128'(1));
            chk("t6_first_den_max", 128'(den_t[0] - r <= PERIOD + 3), 128'(1));
        end
        scan_en = 1'b0;
        repeat (20) @(negedge aclk);
        lat_of[0] = 3;
        chk("sb_empty", 128'(sbq.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
